// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter:
// parity mode codes, the frame FSM states and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // data_xor is the XOR-reduction of the data word; odd mode inverts it
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO that queues words for the transmitter.
// Pushes while full are dropped; the head word is visible on dout whenever not empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, bit divider and frame FSM.
// Frames are sent back-to-back with no idle gap while words are queued.
module uart_tx_param #(
    parameter int CLK_DIV    = 5000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 en_data_in,
    output logic                 rdy,
    output logic                 TX,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 pop;
    logic                 wrap;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (en_data_in),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rdy  = !fifo_full;
    assign busy = (state_q != IDLE) || (fifo_count != '0);
    assign TX   = tx_q;
    assign wrap = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // The line only changes on a divider wrap, or on the pop edge that leaves IDLE
    always_comb begin
        state_d = state_q;
        div_d   = wrap ? '0 : div_q + DIV_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = parity_bit(^fifo_dout, PARITY);
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (wrap) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            tx_d    = par_q;
                            state_d = PAR;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            PAR: begin
                if (wrap) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when a word is waiting
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_dout;
                            par_d   = parity_bit(^fifo_dout, PARITY);
                            tx_d    = 1'b0;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
